// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequencer that feeds a downstream register-file/ALU stage.
//
// Instruction words {instr, imm} enter a small queue. A four-state FSM
// (IDLE -> EXEC -> [FLAG] -> IDLE, or -> HALT) pops one word at a time into the
// instruction register (IR) and decodes the downstream controls from state and
// IR only.
//
// Configuration macro:
//   ALU_SEQ_FIFO_EN  defined   : 4-entry FIFO queue.
//                    undefined : single holding register.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   in_valid    in   instruction word offered
//   in_ready    out  queue not full (transfer when in_valid & in_ready)
//   instr[12:0] in   {kind[1:0], op[1:0], dst[2:0], srca[2:0], srcb[2:0]}
//   imm[15:0]   in   LOAD immediate, captured with instr
//   cout_in     in   registered carry from the downstream stage
//   sel         out  write-data select (0 = immediate, 1 = ALU result)
//   wr          out  register-file write enable
//   op[1:0]     out  ALU operation code
//   rd_addr_a/b out  read register addresses
//   wr_addr     out  write register address
//   d_out[15:0] out  immediate data to the downstream stage
//   busy        out  EXEC or FLAG, or queue non-empty
//   halted      out  FSM is in HALT
//   carry_flag  out  carry of the last completed ALU instruction
//   done_pulse  out  high on the final cycle of each instruction
// -----------------------------------------------------------------------------
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:0] instr,
    input  logic [15:0] imm,
    input  logic        cout_in,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_out,
    output logic        busy,
    output logic        halted,
    output logic        carry_flag,
    output logic        done_pulse
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FLAG, ST_HALT} state_e;
    typedef enum logic [1:0] {K_LOAD = 2'b00, K_ALU = 2'b01, K_NOP = 2'b10, K_HALT = 2'b11} kind_e;

    // Field order matches {instr, imm} so the packed word is a plain concatenation.
    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  op;
        logic [2:0]  dst;
        logic [2:0]  srca;
        logic [2:0]  srcb;
        logic [15:0] imm;
    } word_t;

    state_e state_q, state_d;
    word_t  ir_q, ir_d;
    logic   carry_q, carry_d;

    word_t  in_word;
    word_t  q_head;
    logic   q_full, q_empty;
    logic   push, pop;

    assign in_word  = {instr, imm};
    assign in_ready = ~q_full;
    assign push     = in_valid & ~q_full & ~reset;
    // The FSM only looks at registered queue state, so a word pushed this
    // edge can be popped at the earliest on the following edge.
    assign pop      = (state_q == ST_IDLE) & ~q_empty;

`ifdef ALU_SEQ_FIFO_EN
    word_t      mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;

    assign q_full  = (count_q == 3'd4);
    assign q_empty = (count_q == 3'd0);
    assign q_head  = mem_q[rd_ptr_q];

    // NOTE: storage is not reset; occupancy is tracked by count_q, so stale
    // entries are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    word_t hold_q;
    logic  hold_valid_q;

    assign q_full  = hold_valid_q;
    assign q_empty = ~hold_valid_q;
    assign q_head  = hold_q;

    always_ff @(posedge clk) begin
        if (push) hold_q <= in_word;
    end

    // Push and pop are mutually exclusive: push needs an empty holder,
    // pop needs a full one.
    always_ff @(posedge clk) begin
        if (reset)     hold_valid_q <= 1'b0;
        else if (push) hold_valid_q <= 1'b1;
        else if (pop)  hold_valid_q <= 1'b0;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    ir_d    = q_head;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (kind_e'(ir_q.kind))
                    K_ALU:   state_d = ST_FLAG;
                    K_HALT:  state_d = ST_HALT;
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_FLAG: begin
                carry_d = cout_in;
                state_d = ST_IDLE;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        sel        = 1'b0;
        wr         = 1'b0;
        op         = 2'b00;
        rd_addr_a  = 3'd0;
        rd_addr_b  = 3'd0;
        wr_addr    = 3'd0;
        d_out      = 16'h0000;
        done_pulse = 1'b0;
        case (state_q)
            ST_EXEC: begin
                case (kind_e'(ir_q.kind))
                    K_LOAD: begin
                        wr         = 1'b1;
                        wr_addr    = ir_q.dst;
                        d_out      = ir_q.imm;
                        done_pulse = 1'b1;
                    end
                    K_ALU: begin
                        sel       = 1'b1;
                        wr        = 1'b1;
                        op        = ir_q.op;
                        rd_addr_a = ir_q.srca;
                        rd_addr_b = ir_q.srcb;
                        wr_addr   = ir_q.dst;
                    end
                    default: done_pulse = 1'b1;
                endcase
            end
            // ALU instructions finish here, one cycle after their EXEC.
            ST_FLAG: done_pulse = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (state_q == ST_EXEC) | (state_q == ST_FLAG) | ~q_empty;
    assign halted     = (state_q == ST_HALT);
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq.
// Expected write-port values are queued when a word is accepted and compared
// whenever the DUT asserts wr; directed checks cover timing and corner cases.
// -----------------------------------------------------------------------------
module tb_alu_seq;

`ifdef ALU_SEQ_FIFO_EN
    localparam int QDEPTH = 4;
`else
    localparam int QDEPTH = 1;
`endif

    localparam logic [1:0] K_LOAD = 2'b00;
    localparam logic [1:0] K_ALU  = 2'b01;
    localparam logic [1:0] K_NOP  = 2'b10;
    localparam logic [1:0] K_HALT = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] instr;
    logic [15:0] imm;
    logic        cout_in;
    logic        sel, wr;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_out;
    logic        busy, halted, carry_flag, done_pulse;

    alu_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .imm        (imm),
        .cout_in    (cout_in),
        .sel        (sel),
        .wr         (wr),
        .op         (op),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .wr_addr    (wr_addr),
        .d_out      (d_out),
        .busy       (busy),
        .halted     (halted),
        .carry_flag (carry_flag),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int wr_seen = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = 0;
    logic [27:0] sb [$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic [1:0] k, input logic [1:0] o,
                                       input logic [2:0] d, input logic [2:0] a,
                                       input logic [2:0] b);
        return {k, o, d, a, b};
    endfunction

    // Expected {sel, op, rd_addr_a, rd_addr_b, wr_addr, d_out} for a writing word.
    function automatic logic [27:0] exp_wr(input logic [12:0] w, input logic [15:0] im);
        logic [1:0] k;
        k = w[12:11];
        if (k == K_LOAD) return {1'b0, 2'b00, 3'd0, 3'd0, w[8:6], im};
        return {1'b1, w[10:9], w[5:3], w[2:0], w[8:6], 16'h0000};
    endfunction

    // Scoreboard: push on acceptance, pop on every write strobe.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (wr) begin
                wr_seen     <= wr_seen + 1;
                prev_wr_cyc <= last_wr_cyc;
                last_wr_cyc <= cyc_n;
                if (sb.size() == 0)
                    check("wr_unexpected", 32'(wr), 32'd0);
                else
                    check("wr_fields", 32'({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_out}),
                          32'(sb.pop_front()));
            end
            if (in_valid && in_ready && (instr[12:11] == K_LOAD || instr[12:11] == K_ALU))
                sb.push_back(exp_wr(instr, imm));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and hold it until accepted; in_valid stays high afterwards.
    task automatic send(input logic [12:0] w, input logic [15:0] im);
        in_valid = 1'b1;
        instr    = w;
        imm      = im;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                tick();
                return;
            end
            tick();
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy) return;
            tick();
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int ws;
        int acc;
        logic [12:0] w;

        // Word offered during reset must be ignored.
        reset    = 1'b1;
        in_valid = 1'b1;
        instr    = mk(K_LOAD, 2'b00, 3'd7, 3'd0, 3'd0);
        imm      = 16'hBEEF;
        cout_in  = 1'b0;
        repeat (3) tick();
        reset    = 1'b0;
        in_valid = 1'b0;

        check("rst_wr", 32'(wr), 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_carry", 32'(carry_flag), 32'd0);
        check("rst_data", 32'({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_out}), 32'd0);
        tick();
        tick();
        check("rst_word_dropped", 32'(busy), 32'd0);
        check("rst_no_write", 32'(wr_seen), 32'd0);

        // LOAD: accepted at edge 0, EXEC in the following cycle after IDLE pop.
        in_valid = 1'b1;
        instr    = mk(K_LOAD, 2'b00, 3'd3, 3'd0, 3'd0);
        imm      = 16'h1234;
        tick();
        in_valid = 1'b0;
        check("load_c1_busy", 32'(busy), 32'd1);
        check("load_c1_wr", 32'(wr), 32'd0);
        tick();
        check("load_c2_wr", 32'(wr), 32'd1);
        check("load_c2_sel", 32'(sel), 32'd0);
        check("load_c2_addr", 32'(wr_addr), 32'd3);
        check("load_c2_data", 32'(d_out), 32'h1234);
        check("load_c2_done", 32'(done_pulse), 32'd1);
        tick();
        check("load_c3_wr", 32'(wr), 32'd0);
        check("load_c3_done", 32'(done_pulse), 32'd0);
        check("load_c3_busy", 32'(busy), 32'd0);

        // ALU: EXEC then FLAG; carry captured at the end of FLAG only.
        in_valid = 1'b1;
        instr    = mk(K_ALU, 2'b01, 3'd5, 3'd1, 3'd2);
        imm      = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        tick();
        check("alu_exec_wr", 32'(wr), 32'd1);
        check("alu_exec_sel", 32'(sel), 32'd1);
        check("alu_exec_addrs", 32'({op, rd_addr_a, rd_addr_b, wr_addr}), 32'({2'b01, 3'd1, 3'd2, 3'd5}));
        check("alu_exec_dout", 32'(d_out), 32'd0);
        check("alu_exec_done", 32'(done_pulse), 32'd0);
        tick();
        check("alu_flag_done", 32'(done_pulse), 32'd1);
        check("alu_flag_wr", 32'(wr), 32'd0);
        check("alu_flag_busy", 32'(busy), 32'd1);
        check("alu_flag_carry_old", 32'(carry_flag), 32'd0);
        cout_in = 1'b1;
        tick();
        cout_in = 1'b0;
        check("alu_carry_set", 32'(carry_flag), 32'd1);
        check("alu_post_done", 32'(done_pulse), 32'd0);
        tick();
        check("alu_carry_hold", 32'(carry_flag), 32'd1);

        // NOP: done in EXEC, no write.
        in_valid = 1'b1;
        instr    = mk(K_NOP, 2'b11, 3'd6, 3'd6, 3'd6);
        tick();
        in_valid = 1'b0;
        tick();
        check("nop_done", 32'(done_pulse), 32'd1);
        check("nop_wr", 32'(wr), 32'd0);
        check("nop_outs", 32'({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_out}), 32'd0);
        tick();
        check("nop_after_done", 32'(done_pulse), 32'd0);

        // Two back-to-back LOADs: ordered, EXECs two cycles apart.
        send(mk(K_LOAD, 2'b00, 3'd1, 3'd0, 3'd0), 16'h1111);
        check("b2b_ready_after_push", 32'(in_ready), 32'(QDEPTH > 1));
        send(mk(K_LOAD, 2'b00, 3'd2, 3'd0, 3'd0), 16'h2222);
        in_valid = 1'b0;
        wait_idle();
        tick();
        check("b2b_exec_gap", 32'(last_wr_cyc - prev_wr_cyc), 32'd2);

        // Mixed stream through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            case (i % 3)
                0:       w = mk(K_ALU, 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
                                3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
                1:       w = mk(K_LOAD, 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
                                3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
                default: w = mk(K_NOP, 2'b00, 3'd0, 3'd0, 3'd0);
            endcase
            cout_in = 1'($urandom_range(1, 0));
            send(w, 16'($urandom_range(16'hFFFF, 0)));
        end
        in_valid = 1'b0;
        wait_idle();

        // Establish carry_flag=1, then reset during EXEC of an ALU.
        cout_in = 1'b1;
        send(mk(K_ALU, 2'b11, 3'd0, 3'd7, 3'd7), 16'h0);
        in_valid = 1'b0;
        wait_idle();
        cout_in = 1'b0;
        check("carry_pre_reset", 32'(carry_flag), 32'd1);

        in_valid = 1'b1;
        instr    = mk(K_ALU, 2'b10, 3'd6, 3'd3, 3'd4);
        tick();
        instr    = mk(K_LOAD, 2'b00, 3'd7, 3'd0, 3'd0);
        imm      = 16'h7777;
        tick();
        check("mid_exec_wr", 32'(wr), 32'd1);
        check("mid_exec_sel", 32'(sel), 32'd1);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check("mid_rst_wr", 32'(wr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_halted", 32'(halted), 32'd0);
        check("mid_rst_carry", 32'(carry_flag), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_done", 32'(done_pulse), 32'd0);
        ws = wr_seen;
        repeat (6) tick();
        check("mid_rst_discard", 32'(wr_seen - ws), 32'd0);
        check("mid_rst_idle", 32'(busy), 32'd0);

        // HALT: queue fills to capacity, nothing issues.
        ws = wr_seen;
        send(mk(K_HALT, 2'b00, 3'd0, 3'd0, 3'd0), 16'h0);
        acc = 0;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            instr    = mk(K_LOAD, 2'b00, 3'(i), 3'd0, 3'd0);
            imm      = 16'(i + 16'h100);
            if (in_ready) acc++;
            tick();
        end
        check("halt_accepted", 32'(acc), 32'(QDEPTH));
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_ready", 32'(in_ready), 32'd0);
        check("halt_busy", 32'(busy), 32'd1);
        check("halt_no_write", 32'(wr_seen - ws), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_ready", 32'(in_ready), 32'd1);
        check("halt_rst_busy", 32'(busy), 32'd0);
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
